// File: rtl/ex_fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard controller.
package ex_fwd_hazard_ctrl_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_WB  = 2'b01;
  localparam logic [1:0] FW_MEM = 2'b10;

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            ld;
  } stage_info_t;

  // The MEM-stage shadow never needs the load flag: a load there is forwarded from WB like any other result.
  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            wr;
  } mem_info_t;

endpackage

// File: rtl/ex_fwd_hazard_ctrl_fwd_sel_calc.sv
// Combinational forwarding-select for one EX operand, evaluated while the consumer is still in ID.
module fwd_sel_calc
  import ex_fwd_hazard_ctrl_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  logic            use_src,
  input  stage_info_t     ex,
  input  mem_info_t       mem,
  output logic [1:0]      sel
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;

  assign src_live = use_src & (src != '0);
  // A load in EX cannot be forwarded yet; that case is covered by the load-use stall.
  assign ex_hit   = src_live & ex.v & ex.wr & ~ex.ld & (ex.rd == src);
  assign mem_hit  = src_live & mem.v & mem.wr & (mem.rd == src);

  // NOTE: assigning the default first means every path writes sel, so no latch is inferred.
  always_comb begin
    sel = FW_RF;
    if (ex_hit)       sel = FW_MEM;
    else if (mem_hit) sel = FW_WB;
  end

endmodule

// File: rtl/ex_fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows EX/MEM destinations, registers operand selects, counts stalls.
module ex_fwd_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_ID,
  input  logic [RA_W-1:0]  rs_ID,
  input  logic [RA_W-1:0]  rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic [RA_W-1:0]  rd_ID,
  input  logic             regwr_ID,
  input  logic             memrd_ID,
  input  logic             flush_EX,
  input  logic             freeze,
  output logic [1:0]       BusAFw,
  output logic [1:0]       BusBFw,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             bubble_EX,
  output logic [CNT_W-1:0] stall_cnt
);

  import ex_fwd_hazard_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  stage_info_t      ex_q;
  mem_info_t        mem_q;
  logic [1:0]       fw_a_q, fw_b_q;
  logic [1:0]       sel_a, sel_b;
  logic [CNT_W-1:0] cnt_q;
  logic             src_hit, hazard, stall, kill_id;

  fwd_sel_calc u_sel_a (
    .src     (rs_ID),
    .use_src (use_rs_ID),
    .ex      (ex_q),
    .mem     (mem_q),
    .sel     (sel_a)
  );

  fwd_sel_calc u_sel_b (
    .src     (rt_ID),
    .use_src (use_rt_ID),
    .ex      (ex_q),
    .mem     (mem_q),
    .sel     (sel_b)
  );

  assign src_hit = (use_rs_ID & (rs_ID == ex_q.rd)) | (use_rt_ID & (rt_ID == ex_q.rd));
  assign hazard  = valid_ID & ex_q.v & ex_q.ld & ex_q.wr & (ex_q.rd != '0) & src_hit;
  // A taken branch kills the consumer anyway, and a frozen pipeline advances nothing.
  assign stall   = hazard & ~flush_EX & ~freeze;
  assign kill_id = flush_EX | stall | ~valid_ID;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      fw_a_q <= FW_RF;
      fw_b_q <= FW_RF;
      cnt_q  <= '0;
    end else if (!freeze) begin
      mem_q <= '{v: ex_q.v, rd: ex_q.rd, wr: ex_q.wr};
      if (kill_id) begin
        ex_q   <= '0;
        fw_a_q <= FW_RF;
        fw_b_q <= FW_RF;
      end else begin
        ex_q   <= '{v: 1'b1, rd: rd_ID, wr: regwr_ID, ld: memrd_ID};
        fw_a_q <= sel_a;
        fw_b_q <= sel_b;
      end
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign BusAFw    = fw_a_q;
  assign BusBFw    = fw_b_q;
  assign stall_IF  = stall;
  assign stall_ID  = stall;
  assign bubble_EX = stall;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_fwd_hazard_ctrl.sv
// Scoreboard bench: the driver queues the expected outputs for each ID cycle, a monitor compares them.
module tb_ex_fwd_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 2;   // narrow counter so saturation is reachable

  typedef struct {
    logic            v;
    logic [RA_W-1:0] rs, rt, rd;
    logic            urs, urt, wr, ld;
  } id_t;

  typedef struct {
    logic [1:0]       fa, fb;
    logic             st;
    logic [CNT_W-1:0] cnt;
    string            nm;
  } exp_t;

  logic             clk, rst_n;
  logic             valid_ID, use_rs_ID, use_rt_ID, regwr_ID, memrd_ID, flush_EX, freeze;
  logic [RA_W-1:0]  rs_ID, rt_ID, rd_ID;
  logic [1:0]       BusAFw, BusBFw;
  logic             stall_IF, stall_ID, bubble_EX;
  logic [CNT_W-1:0] stall_cnt;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  event sample_now;

  ex_fwd_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_ID  (valid_ID),
    .rs_ID     (rs_ID),
    .rt_ID     (rt_ID),
    .use_rs_ID (use_rs_ID),
    .use_rt_ID (use_rt_ID),
    .rd_ID     (rd_ID),
    .regwr_ID  (regwr_ID),
    .memrd_ID  (memrd_ID),
    .flush_EX  (flush_EX),
    .freeze    (freeze),
    .BusAFw    (BusAFw),
    .BusBFw    (BusBFw),
    .stall_IF  (stall_IF),
    .stall_ID  (stall_ID),
    .bubble_EX (bubble_EX),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic id_t nop();
    id_t i;
    i = '{v: 1'b0, rs: '0, rt: '0, rd: '0, urs: 1'b0, urt: 1'b0, wr: 1'b0, ld: 1'b0};
    return i;
  endfunction

  function automatic id_t alu(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs, input logic urs,
                              input logic [RA_W-1:0] rt, input logic urt);
    id_t i;
    i = '{v: 1'b1, rs: rs, rt: rt, rd: rd, urs: urs, urt: urt, wr: 1'b1, ld: 1'b0};
    return i;
  endfunction

  function automatic id_t load(input logic [RA_W-1:0] rd);
    id_t i;
    i = '{v: 1'b1, rs: '0, rt: '0, rd: rd, urs: 1'b0, urt: 1'b0, wr: 1'b1, ld: 1'b1};
    return i;
  endfunction

  task automatic drive(input id_t i, input logic fl, input logic fz);
    valid_ID  = i.v;
    rs_ID     = i.rs;
    rt_ID     = i.rt;
    use_rs_ID = i.urs;
    use_rt_ID = i.urt;
    rd_ID     = i.rd;
    regwr_ID  = i.wr;
    memrd_ID  = i.ld;
    flush_EX  = fl;
    freeze    = fz;
  endtask

  task automatic expect_out(input logic [1:0] fa, input logic [1:0] fb, input logic st,
                            input logic [CNT_W-1:0] cnt, input string nm);
    exp_t e;
    e = '{fa: fa, fb: fb, st: st, cnt: cnt, nm: nm};
    q.push_back(e);
  endtask

  // One ID cycle: apply inputs, queue what the outputs must show this cycle, advance past the edge.
  task automatic step(input id_t i, input logic fl, input logic fz, input logic [1:0] fa, input logic [1:0] fb,
                      input logic st, input logic [CNT_W-1:0] cnt, input string nm);
    drive(i, fl, fz);
    expect_out(fa, fb, st, cnt, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input exp_t e);
    tests++;
    if (BusAFw !== e.fa || BusBFw !== e.fb || stall_IF !== e.st || stall_ID !== e.st ||
        bubble_EX !== e.st || stall_cnt !== e.cnt) begin
      fails++;
      $display("FAIL %s: got A=%b B=%b sIF=%b sID=%b bub=%b cnt=%0d, want A=%b B=%b stall=%b cnt=%0d",
               e.nm, BusAFw, BusBFw, stall_IF, stall_ID, bubble_EX, stall_cnt, e.fa, e.fb, e.st, e.cnt);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or sample_now);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e);
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    drive(nop(), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step(nop(), 0, 0, 2'b00, 2'b00, 0, 0, "reset_state");
    rst_n = 1'b1;

    // ALU r3 then rt=r3 reader: EX forwarding on B.
    step(alu(3, 0, 0, 0, 0),  0, 0, 2'b00, 2'b00, 0, 0, "alu_prod");
    step(alu(8, 0, 0, 3, 1),  0, 0, 2'b00, 2'b00, 0, 0, "alu_cons_id");
    step(nop(),               0, 0, 2'b00, 2'b10, 0, 0, "alu_fwd_b_mem");

    // ALU r3, independent, then rs=r3 reader: WB forwarding on A.
    step(alu(3, 0, 0, 0, 0),  0, 0, 2'b00, 2'b00, 0, 0, "wb_prod");
    step(alu(9, 0, 0, 0, 0),  0, 0, 2'b00, 2'b00, 0, 0, "wb_indep");
    step(alu(10, 3, 1, 4, 1), 0, 0, 2'b00, 2'b00, 0, 0, "wb_cons_id");
    step(nop(),               0, 0, 2'b01, 2'b00, 0, 0, "wb_fwd_a");
    step(nop(),               0, 0, 2'b00, 2'b00, 0, 0, "drain1");

    // Load r5 then rt=r5 reader: one stall cycle, then WB forwarding.
    step(load(5),             0, 0, 2'b00, 2'b00, 0, 0, "lu_load");
    step(alu(11, 0, 0, 5, 1), 0, 0, 2'b00, 2'b00, 1, 1'b0, "lu_stall");
    step(alu(11, 0, 0, 5, 1), 0, 0, 2'b00, 2'b00, 0, 1, "lu_release");
    step(nop(),               0, 0, 2'b00, 2'b01, 0, 1, "lu_fwd_b");
    step(nop(),               0, 0, 2'b00, 2'b00, 0, 1, "drain2");

    // Load r5 with dependent in ID and a flush: flush wins, EX slot killed.
    step(load(5),             0, 0, 2'b00, 2'b00, 0, 1, "fl_load");
    step(alu(11, 0, 0, 5, 1), 1, 0, 2'b00, 2'b00, 0, 1, "fl_no_stall");
    step(alu(0, 5, 1, 0, 0),  0, 0, 2'b00, 2'b00, 0, 1, "fl_ex_killed");
    step(nop(),               0, 0, 2'b01, 2'b00, 0, 1, "fl_fwd_a_from_mem");
    step(nop(),               0, 0, 2'b00, 2'b00, 0, 1, "drain3");

    // Back-to-back r7 writers: youngest wins; r0 never forwards or stalls.
    step(alu(7, 0, 0, 0, 0),  0, 0, 2'b00, 2'b00, 0, 1, "r7_old");
    step(alu(7, 0, 0, 0, 0),  0, 0, 2'b00, 2'b00, 0, 1, "r7_new");
    step(alu(12, 7, 1, 7, 1), 0, 0, 2'b00, 2'b00, 0, 1, "r7_cons_id");
    step(alu(13, 0, 1, 0, 1), 0, 0, 2'b10, 2'b10, 0, 1, "r7_fwd_both");
    step(load(0),             0, 0, 2'b00, 2'b00, 0, 1, "r0_cons_sel");
    step(alu(0, 0, 1, 13, 1), 0, 0, 2'b00, 2'b00, 0, 1, "r0_load_no_stall");
    step(nop(),               0, 0, 2'b00, 2'b01, 0, 1, "r0_a_rf_b_wb");
    step(nop(),               0, 0, 2'b00, 2'b00, 0, 1, "drain4");

    // Freeze for 3 cycles across a load-use hazard.
    step(load(6),             0, 0, 2'b00, 2'b00, 0, 1, "fz_load");
    step(alu(14, 6, 1, 0, 0), 0, 1, 2'b00, 2'b00, 0, 1, "fz_hold1");
    step(alu(14, 6, 1, 0, 0), 0, 1, 2'b00, 2'b00, 0, 1, "fz_hold2");
    step(alu(14, 6, 1, 0, 0), 0, 1, 2'b00, 2'b00, 0, 1, "fz_hold3");
    step(alu(14, 6, 1, 0, 0), 0, 0, 2'b00, 2'b00, 1, 1, "fz_stall");
    step(alu(14, 6, 1, 0, 0), 0, 0, 2'b00, 2'b00, 0, 2, "fz_release");
    step(nop(),               0, 1, 2'b01, 2'b00, 0, 2, "fz_sel_frozen");
    step(nop(),               0, 0, 2'b01, 2'b00, 0, 2, "fz_sel_held");

    // Two more load-use stalls: counter reaches all-ones and saturates.
    step(load(5),             0, 0, 2'b00, 2'b00, 0, 2, "sat_load1");
    step(alu(15, 0, 0, 5, 1), 0, 0, 2'b00, 2'b00, 1, 2, "sat_stall1");
    step(alu(15, 0, 0, 5, 1), 0, 0, 2'b00, 2'b00, 0, 3, "sat_cnt3");
    step(load(5),             0, 0, 2'b00, 2'b01, 0, 3, "sat_load2");
    step(alu(15, 0, 0, 5, 1), 0, 0, 2'b00, 2'b00, 1, 3, "sat_stall2");
    step(alu(15, 0, 0, 5, 1), 0, 0, 2'b00, 2'b00, 0, 3, "sat_held");
    step(load(5),             0, 0, 2'b00, 2'b01, 0, 3, "rst_load");

    // Reset asserted mid-stall, between clock edges.
    drive(alu(15, 0, 0, 5, 1), 1'b0, 1'b0);
    expect_out(2'b00, 2'b00, 1'b1, 3, "rst_pre_stall");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out(2'b00, 2'b00, 1'b0, 0, "async_reset");
    ->sample_now;
    @(posedge clk);
    #1;
    step(alu(15, 0, 0, 5, 1), 0, 0, 2'b00, 2'b00, 0, 0, "reset_held");
    rst_n = 1'b1;
    step(nop(),               0, 0, 2'b00, 2'b00, 0, 0, "post_reset");

    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d expected entries never compared, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
